// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one bit per clock, LSB first.
// A start in IDLE captures both operands and the carry-in. RUN then
// consumes WIDTH bits. DONE raises a one-cycle done pulse while the
// completed sum and carry-out are published on registered outputs.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The bit counter only has to reach WIDTH-1. The RUN edge that sees
    // that value is the last one.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Reject widths outside the supported range at elaboration time.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;        // operand A, shifted right once per RUN edge
    logic [WIDTH-1:0] b_q;        // operand B, shifted right once per RUN edge
    logic             c_q;        // running carry
    logic [WIDTH-1:0] res_q;      // partial result, filled from the MSB side
    logic [CW-1:0]    cnt_q;      // number of bits already processed
    logic [WIDTH-1:0] sum_q;      // published result, changes only on completion
    logic             cout_q;     // published carry-out
    logic             busy_q;
    logic             done_q;

    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_d;

    // Full-adder slice on the current LSBs, plus next values of the shifters.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path, so no storage can be inferred. Here that holds because each
        // signal is assigned unconditionally.
        sum_bit = a_q[0] ^ b_q[0] ^ c_q;
        carry_d = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
    end

    // Control FSM and datapath registers. The outputs are registered so that
    // busy and done line up exactly with the RUN and DONE states.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // right-hand side reads the value from before this edge. That keeps
        // the order of the statements below irrelevant.
        if (rst) begin
            // NOTE: the shift registers are ordinary flops, not a memory
            // array, so they are cleared together with the control state.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    // start and the operand inputs are not looked at here.
                    a_q   <= a_d;
                    b_q   <= b_d;
                    c_q   <= carry_d;
                    res_q <= res_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_BIT) begin
                        // Publish the whole word at once. The partial bits
                        // in res_q never reach the sum output.
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8). Expected results are computed with
// a plain integer add, queued when an operation is started, and compared
// when done pulses. Directed steps cover reset, latency, hold, ignored
// start, mid-run reset and back-to-back throughput.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } res_t;

    res_t exp_q[$];
    res_t mon_exp;
    int   tests      = 0;
    int   fails      = 0;
    int   done_count = 0;
    int   pushes     = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic ci);
        logic [WIDTH:0] full;
        res_t r;
        full   = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, ci};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        return r;
    endfunction

    // Scoreboard: each done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            check("busy_low_in_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_sum", {24'd0, sum}, {24'd0, mon_exp.sum});
                check("sb_cout", {31'd0, cout}, {31'd0, mon_exp.cout});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted start (the DUT must be in IDLE) and queue its result.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci);
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        exp_q.push_back(model(av, bv, ci));
        pushes++;
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    // Called just after the accepting edge. It counts edges, including the
    // accepting edge, up to and including the one that raises done.
    task automatic wait_done(input string tag, output int edges, output int busy_cyc);
        bit found;
        found    = 1'b0;
        edges    = 1;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            edges++;
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int e;
        int bc;
        int dc0;
        int k;
        bit hold_ok;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        // 0 + 0: busy for WIDTH cycles, done on the 9th edge.
        issue(8'h00, 8'h00, 1'b0);
        wait_done("zero", e, bc);
        check("zero_busy_cycles", bc, 8);
        check("zero_latency", e, 9);
        tick();

        // 0xFF + 0x01: wraps to 0 with a carry out.
        issue(8'hFF, 8'h01, 1'b0);
        wait_done("wrap", e, bc);
        check("wrap_latency", e, 9);
        check("wrap_sum_direct", {24'd0, sum}, 32'h00);
        check("wrap_cout_direct", {31'd0, cout}, 32'd1);
        tick();

        // 0x5A + 0x3C + 1 = 0x97. The result must then hold for 20 idle cycles.
        issue(8'h5A, 8'h3C, 1'b1);
        wait_done("mix", e, bc);
        check("mix_sum_direct", {24'd0, sum}, 32'h97);
        tick();
        hold_ok = 1'b1;
        repeat (20) begin
            tick();
            if (sum !== 8'h97 || cout !== 1'b0 || done !== 1'b0 || busy !== 1'b0) hold_ok = 1'b0;
        end
        check("mix_hold_20", {31'd0, hold_ok}, 32'd1);

        // 0xFF + 0xFF + 1 = 0x1FF.
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done("max", e, bc);
        check("max_cout_direct", {31'd0, cout}, 32'd1);
        tick();

        // A start pulse during RUN is ignored. Only one done pulse, result 0x97.
        dc0 = done_count;
        issue(8'h5A, 8'h3C, 1'b1);
        tick();
        tick();
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore", e, bc);
        check("ignore_sum_direct", {24'd0, sum}, 32'h97);
        repeat (15) tick();
        check("ignore_one_done", done_count - dc0, 1);

        // Reset in the 4th RUN cycle aborts the operation. No done pulse,
        // and the outputs are cleared.
        a     = 8'h5A;
        b     = 8'h3C;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'h00);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        dc0 = done_count;
        repeat (12) tick();
        check("abort_no_done", done_count - dc0, 0);
        issue(8'h10, 8'h20, 1'b0);
        wait_done("after_abort", e, bc);
        check("after_abort_latency", e, 9);
        check("after_abort_sum_direct", {24'd0, sum}, 32'h30);
        tick();

        // Back-to-back: start held high gives a period of WIDTH+2 edges
        // between done pulses.
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        pushes++;
        tick();
        a   = 8'hC8;
        b   = 8'h41;
        cin = 1'b1;
        exp_q.push_back(model(8'hC8, 8'h41, 1'b1));
        pushes++;
        wait_done("b2b_first", e, bc);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (k == 2) start = 1'b0;
            if (done === 1'b1) break;
        end
        check("b2b_period", k, WIDTH + 2);
        tick();

        // A few random operands through the scoreboard.
        for (int n = 0; n < 6; n++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done("rand", e, bc);
            check("rand_latency", e, 9);
            tick();
        end

        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);
        check("done_total", done_count, pushes);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits, legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 Port: cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at a rising edge SHALL load a and b into internal shift registers, load cin into the carry flop, clear the bit counter, and move to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 In RUN, each rising edge SHALL process one bit, LSB first.
REQ-016 For each processed bit, s = a0 XOR b0 XOR c and c_next = (a0 AND b0) OR (c AND (a0 XOR b0)).
REQ-017 After each processed bit, the operand registers SHALL shift right and s SHALL shift into the MSB of an internal result shift register.
REQ-018 The bit counter SHALL increment once per RUN edge.
REQ-019 On the WIDTH-th RUN edge, the block SHALL copy the completed result to sum, copy the final carry to cout, and move to DONE.
REQ-020 DONE SHALL last exactly one cycle and SHALL move to IDLE unconditionally.
REQ-021 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th rising edge, counted from and including the edge that accepted start.
REQ-022 busy SHALL be 1 exactly in RUN (WIDTH cycles) and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 exactly in DONE.
REQ-024 start in RUN or DONE SHALL be ignored, and a, b, cin SHALL not be re-sampled.
REQ-025 Operand inputs SHALL be don't-care except at the accepting edge.
REQ-026 sum and cout SHALL hold their value from completion until the next completion or reset; intermediate bits SHALL never appear on sum.
REQ-027 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH of the full sum; overflow wraps with no other indication.
REQ-028 Back-to-back operation: start held high SHALL be accepted again in the IDLE cycle after DONE, giving a WIDTH+2 cycle throughput period.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, sum, cout, the carry flop, the bit counter, and all shift registers to 0.
REQ-030 rst SHALL take priority over start and over any RUN or DONE activity.
REQ-031 Reset mid-RUN SHALL abort the operation with no done pulse, and sum/cout SHALL read 0.
REQ-032 The first start after rst is released SHALL be accepted normally.

Verification (WIDTH=8)
REQ-033 Scenario: a=0x00, b=0x00, cin=0, start pulse -> busy high for 8 cycles, then done pulse; sum=0x00, cout=0.
REQ-034 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, with done exactly 9 edges after the start edge.
REQ-035 Scenario: a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0; sum holds 0x97 for 20 idle cycles afterwards.
REQ-036 Scenario: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-037 Scenario: start the 0x5A+0x3C op, then in RUN pulse start with a=0x01, b=0x01 -> second start ignored; result is 0x97 and exactly one done pulse.
REQ-038 Scenario: start the op, assert rst on the 4th RUN cycle -> busy=0, sum=0x00, cout=0, no done; then 0x10+0x20, cin=0 -> sum=0x30, cout=0.
